image_boot_sequencer: RTL and testbench

//  Boot/run controller for Simple_Single_CPU. Consumes one 32-bit word stream holding the instruction

---
 rtl/image_boot_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 tb/tb_image_boot_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_boot_sequencer.sv
// ---------------------------------------------------------------------------
// image_boot_sequencer
//
// Boot/run controller for Simple_Single_CPU. A single 32-bit word stream
// carries the instruction image (PC, N, N words) followed by the data image
// (SP, M, M words). Instruction words are written to IM byte by byte in
// big-endian order starting at PC. Data words are written to DM byte by byte
// in little-endian order starting at address 0. PC and $sp are handed to the
// CPU with one-cycle load strobes, then the CPU is released. It runs until
// the halt opcode 6'h3f is seen, and the number of run cycles is reported.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous reset, active high
//   s_valid_i    stream word valid
//   s_data_i     stream word
//   s_ready_o    sequencer accepts a word on this edge
//   im_we_o      IM byte write strobe, im_addr_o / im_wdata_o
//   dm_we_o      DM byte write strobe, dm_addr_o / dm_wdata_o
//   pc_we_o      one-cycle strobe: load pc_o into the PC
//   sp_we_o      one-cycle strobe: load sp_o into Reg_File[29]
//   instr_op_i   opcode of the instruction the CPU is executing
//   cpu_run_o    CPU clock enable / release
//   halt_o       sticky: halt opcode seen while running
//   err_o        sticky: an image word count exceeded MAX_WORDS
//   cycle_cnt_o  run cycles executed, saturating
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module image_boot_sequencer #(
  parameter int IM_AW     = 10,
  parameter int DM_AW     = 10,
  parameter int MAX_WORDS = 256
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_valid_i,
  input  logic [31:0]      s_data_i,
  output logic             s_ready_o,
  output logic             im_we_o,
  output logic [IM_AW-1:0] im_addr_o,
  output logic [7:0]       im_wdata_o,
  output logic             dm_we_o,
  output logic [DM_AW-1:0] dm_addr_o,
  output logic [7:0]       dm_wdata_o,
  output logic             pc_we_o,
  output logic [31:0]      pc_o,
  output logic             sp_we_o,
  output logic [31:0]      sp_o,
  input  logic [5:0]       instr_op_i,
  output logic             cpu_run_o,
  output logic             halt_o,
  output logic             err_o,
  output logic [31:0]      cycle_cnt_o
);

  // Word index and word count must both hold MAX_WORDS itself.
  localparam int          KW      = $clog2(MAX_WORDS + 1);
  localparam logic [31:0] MAX_W   = 32'(MAX_WORDS);
  localparam logic [5:0]  OP_HALT = 6'h3f;
  localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    I_PC   = 4'd0,
    I_CNT  = 4'd1,
    I_WORD = 4'd2,
    I_BYTE = 4'd3,
    D_SP   = 4'd4,
    D_CNT  = 4'd5,
    D_WORD = 4'd6,
    D_BYTE = 4'd7,
    RUN    = 4'd8,
    HALT   = 4'd9,
    ERR    = 4'd10
  } state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [KW-1:0]    cnt_q, cnt_d;
  logic [1:0]       b_q, b_d;
  logic [31:0]      word_q, word_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      sp_q, sp_d;
  logic             pc_we_q, pc_we_d;
  logic             sp_we_q, sp_we_d;
  logic             ready_q, ready_d;
  logic             run_q, run_d;
  logic             halt_q, halt_d;
  logic             err_q, err_d;
  logic [31:0]      cyc_q, cyc_d;
  logic             im_we_q, im_we_d;
  logic [IM_AW-1:0] im_addr_q, im_addr_d;
  logic [7:0]       im_wdata_q, im_wdata_d;
  logic             dm_we_q, dm_we_d;
  logic [DM_AW-1:0] dm_addr_q, dm_addr_d;
  logic [7:0]       dm_wdata_q, dm_wdata_d;

  logic             accept_s;
  logic             last_word_s;
  logic             im_wr_s;
  logic             dm_wr_s;

  // Byte lane idx of a word, lane 0 being bits [7:0].
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] r;
    case (idx)
      2'd0:    r = w[7:0];
      2'd1:    r = w[15:8];
      2'd2:    r = w[23:16];
      default: r = w[31:24];
    endcase
    return r;
  endfunction

  assign accept_s    = s_valid_i & ready_q;
  assign last_word_s = ((k_q + KW'(1)) == cnt_q);

  // Next-state logic: stream parsing, byte sequencing, run/halt control.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    word_d  = word_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    pc_we_d = 1'b0;
    sp_we_d = 1'b0;
    halt_d  = halt_q;
    err_d   = err_q;
    cyc_d   = cyc_q;
    im_wr_s = 1'b0;
    dm_wr_s = 1'b0;

    case (state_q)
      I_PC: begin
        if (accept_s) begin
          pc_d    = s_data_i;
          pc_we_d = 1'b1;
          state_d = I_CNT;
        end else begin
          state_d = I_PC;
        end
      end
      I_CNT: begin
        if (accept_s) begin
          if (s_data_i > MAX_W) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else if (s_data_i == 32'd0) begin
            state_d = D_SP;
          end else begin
            cnt_d   = s_data_i[KW-1:0];
            k_d     = '0;
            state_d = I_WORD;
          end
        end else begin
          state_d = I_CNT;
        end
      end
      I_WORD: begin
        // First byte is issued on the accept edge so the four writes
        // occupy exactly the four I_BYTE cycles.
        if (accept_s) begin
          word_d  = s_data_i;
          b_d     = 2'd0;
          im_wr_s = 1'b1;
          state_d = I_BYTE;
        end else begin
          state_d = I_WORD;
        end
      end
      I_BYTE: begin
        if (b_q == 2'd3) begin
          if (last_word_s) begin
            state_d = D_SP;
          end else begin
            k_d     = k_q + KW'(1);
            state_d = I_WORD;
          end
        end else begin
          b_d     = b_q + 2'd1;
          im_wr_s = 1'b1;
        end
      end
      D_SP: begin
        if (accept_s) begin
          sp_d    = s_data_i;
          sp_we_d = 1'b1;
          state_d = D_CNT;
        end else begin
          state_d = D_SP;
        end
      end
      D_CNT: begin
        if (accept_s) begin
          if (s_data_i > MAX_W) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else if (s_data_i == 32'd0) begin
            state_d = RUN;
          end else begin
            cnt_d   = s_data_i[KW-1:0];
            k_d     = '0;
            state_d = D_WORD;
          end
        end else begin
          state_d = D_CNT;
        end
      end
      D_WORD: begin
        if (accept_s) begin
          word_d  = s_data_i;
          b_d     = 2'd0;
          dm_wr_s = 1'b1;
          state_d = D_BYTE;
        end else begin
          state_d = D_WORD;
        end
      end
      D_BYTE: begin
        if (b_q == 2'd3) begin
          if (last_word_s) begin
            state_d = RUN;
          end else begin
            k_d     = k_q + KW'(1);
            state_d = D_WORD;
          end
        end else begin
          b_d     = b_q + 2'd1;
          dm_wr_s = 1'b1;
        end
      end
      RUN: begin
        // The halting cycle is itself counted.
        if (cyc_q != CNT_SAT) begin
          cyc_d = cyc_q + 32'd1;
        end else begin
          cyc_d = cyc_q;
        end
        if (instr_op_i == OP_HALT) begin
          halt_d  = 1'b1;
          state_d = HALT;
        end else begin
          state_d = RUN;
        end
      end
      HALT:    state_d = HALT;
      ERR:     state_d = ERR;
      default: state_d = I_PC;
    endcase
  end

  // Registered-output next values derived from the next state and byte slot.
  always_comb begin
    case (state_d)
      I_PC, I_CNT, I_WORD, D_SP, D_CNT, D_WORD: ready_d = 1'b1;
      default:                                  ready_d = 1'b0;
    endcase
    run_d   = (state_d == RUN);
    im_we_d = im_wr_s;
    dm_we_d = dm_wr_s;
    // Byte offset 4k+b is {k,b}; the cast wraps it into the memory size.
    if (im_wr_s) begin
      im_addr_d  = pc_q[IM_AW-1:0] + IM_AW'({k_d, b_d});
      im_wdata_d = byte_of(word_d, ~b_d);
    end else begin
      im_addr_d  = im_addr_q;
      im_wdata_d = im_wdata_q;
    end
    if (dm_wr_s) begin
      dm_addr_d  = DM_AW'({k_d, b_d});
      dm_wdata_d = byte_of(word_d, b_d);
    end else begin
      dm_addr_d  = dm_addr_q;
      dm_wdata_d = dm_wdata_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= I_PC;
      k_q        <= '0;
      cnt_q      <= '0;
      b_q        <= 2'd0;
      word_q     <= 32'd0;
      pc_q       <= 32'd0;
      sp_q       <= 32'd0;
      pc_we_q    <= 1'b0;
      sp_we_q    <= 1'b0;
      ready_q    <= 1'b0;
      run_q      <= 1'b0;
      halt_q     <= 1'b0;
      err_q      <= 1'b0;
      cyc_q      <= 32'd0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= 8'd0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      b_q        <= b_d;
      word_q     <= word_d;
      pc_q       <= pc_d;
      sp_q       <= sp_d;
      pc_we_q    <= pc_we_d;
      sp_we_q    <= sp_we_d;
      ready_q    <= ready_d;
      run_q      <= run_d;
      halt_q     <= halt_d;
      err_q      <= err_d;
      cyc_q      <= cyc_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
    end
  end

  assign s_ready_o   = ready_q;
  assign im_we_o     = im_we_q;
  assign im_addr_o   = im_addr_q;
  assign im_wdata_o  = im_wdata_q;
  assign dm_we_o     = dm_we_q;
  assign dm_addr_o   = dm_addr_q;
  assign dm_wdata_o  = dm_wdata_q;
  assign pc_we_o     = pc_we_q;
  assign pc_o        = pc_q;
  assign sp_we_o     = sp_we_q;
  assign sp_o        = sp_q;
  assign cpu_run_o   = run_q;
  assign halt_o      = halt_q;
  assign err_o       = err_q;
  assign cycle_cnt_o = cyc_q;

endmodule

// File: tb/tb_image_boot_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for image_boot_sequencer. Images are generated with $urandom;
// expected IM/DM byte writes, PC/SP values, run latency and cycle counts are
// computed from the image contents with plain arithmetic and checked against
// what the DUT produces.
// ---------------------------------------------------------------------------
module tb_image_boot_sequencer;

  localparam int          IM_AW     = 10;
  localparam int          DM_AW     = 10;
  localparam int          MAX_WORDS = 256;
  localparam logic [31:0] IM_MASK   = (32'd1 << IM_AW) - 32'd1;
  localparam logic [31:0] DM_MASK   = (32'd1 << DM_AW) - 32'd1;
  localparam logic [5:0]  OP_HALT   = 6'h3f;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             s_valid_i;
  logic [31:0]      s_data_i;
  logic             s_ready_o;
  logic             im_we_o;
  logic [IM_AW-1:0] im_addr_o;
  logic [7:0]       im_wdata_o;
  logic             dm_we_o;
  logic [DM_AW-1:0] dm_addr_o;
  logic [7:0]       dm_wdata_o;
  logic             pc_we_o;
  logic [31:0]      pc_o;
  logic             sp_we_o;
  logic [31:0]      sp_o;
  logic [5:0]       instr_op_i;
  logic             cpu_run_o;
  logic             halt_o;
  logic             err_o;
  logic [31:0]      cycle_cnt_o;

  image_boot_sequencer #(.IM_AW(IM_AW), .DM_AW(DM_AW), .MAX_WORDS(MAX_WORDS)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .s_valid_i  (s_valid_i),
    .s_data_i   (s_data_i),
    .s_ready_o  (s_ready_o),
    .im_we_o    (im_we_o),
    .im_addr_o  (im_addr_o),
    .im_wdata_o (im_wdata_o),
    .dm_we_o    (dm_we_o),
    .dm_addr_o  (dm_addr_o),
    .dm_wdata_o (dm_wdata_o),
    .pc_we_o    (pc_we_o),
    .pc_o       (pc_o),
    .sp_we_o    (sp_we_o),
    .sp_o       (sp_o),
    .instr_op_i (instr_op_i),
    .cpu_run_o  (cpu_run_o),
    .halt_o     (halt_o),
    .err_o      (err_o),
    .cycle_cnt_o(cycle_cnt_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] im_wq[$];
  logic [31:0] dm_wq[$];
  logic [31:0] exp_im_a[$];
  logic [31:0] exp_im_d[$];
  logic [31:0] exp_dm_a[$];
  logic [31:0] exp_dm_d[$];
  int          im_cnt, dm_cnt, pc_cnt, sp_cnt;
  logic [31:0] exp_pc, exp_sp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Write monitor: every strobe is compared in order against the model.
  always @(negedge clk) begin
    if (im_we_o === 1'b1 || dm_we_o === 1'b1)
      check("we_exclusive", 32'(im_we_o & dm_we_o), 32'd0);
    if (im_we_o === 1'b1) begin
      im_cnt++;
      if (exp_im_a.size() > 0) begin
        check("im_addr", 32'(im_addr_o), exp_im_a.pop_front());
        check("im_data", 32'(im_wdata_o), exp_im_d.pop_front());
      end
    end
    if (dm_we_o === 1'b1) begin
      dm_cnt++;
      if (exp_dm_a.size() > 0) begin
        check("dm_addr", 32'(dm_addr_o), exp_dm_a.pop_front());
        check("dm_data", 32'(dm_wdata_o), exp_dm_d.pop_front());
      end
    end
    if (pc_we_o === 1'b1) begin
      pc_cnt++;
      check("pc_value", pc_o, exp_pc);
    end
    if (sp_we_o === 1'b1) begin
      sp_cnt++;
      check("sp_value", sp_o, exp_sp);
    end
  end

  // Reference: IM big-endian from PC, DM little-endian from 0, both wrapping.
  task automatic build_expect(input logic [31:0] pc);
    for (int k = 0; k < im_wq.size(); k++) begin
      for (int b = 0; b < 4; b++) begin
        exp_im_a.push_back((pc + 32'(4 * k + b)) & IM_MASK);
        exp_im_d.push_back((im_wq[k] >> (24 - 8 * b)) & 32'hFF);
      end
    end
    for (int k = 0; k < dm_wq.size(); k++) begin
      for (int b = 0; b < 4; b++) begin
        exp_dm_a.push_back(32'(4 * k + b) & DM_MASK);
        exp_dm_d.push_back((dm_wq[k] >> (8 * b)) & 32'hFF);
      end
    end
  endtask

  task automatic do_reset();
    rst_i      = 1'b1;
    s_valid_i  = 1'b0;
    s_data_i   = 32'd0;
    instr_op_i = OP_HALT;   // must be ignored while loading
    exp_im_a.delete(); exp_im_d.delete();
    exp_dm_a.delete(); exp_dm_d.delete();
    im_cnt = 0; dm_cnt = 0; pc_cnt = 0; sp_cnt = 0;
    @(posedge clk); #1;
    check("rst_flags", {24'd0, s_ready_o, cpu_run_o, halt_o, err_o,
                        im_we_o, dm_we_o, pc_we_o, sp_we_o}, 32'd0);
    check("rst_cnt", cycle_cnt_o, 32'd0);
    check("rst_pc", pc_o, 32'd0);
    check("rst_sp", sp_o, 32'd0);
    check("rst_im_bus", 32'({im_addr_o, im_wdata_o}), 32'd0);
    check("rst_dm_bus", 32'({dm_addr_o, dm_wdata_o}), 32'd0);
    rst_i = 1'b0;
    check("ready_after_release", 32'(s_ready_o), 32'd0);
  endtask

  // Present one word (optionally after idle gaps) and wait for its accept edge.
  task automatic send_word(input logic [31:0] w, input bit gaps, output bit ok);
    int gap;
    bit rdy;
    gap = gaps ? int'($urandom_range(0, 3)) : 0;
    for (int g = 0; g < gap; g++) begin
      s_valid_i = 1'b0;
      s_data_i  = $urandom;
      @(posedge clk); #1;
    end
    s_valid_i = 1'b1;
    s_data_i  = w;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      rdy = s_ready_o;
      @(posedge clk); #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    s_valid_i = 1'b0;
  endtask

  // Load im_wq/dm_wq, then run halt_after cycles (0: stay in RUN and return).
  task automatic run_image(input logic [31:0] pc, input logic [31:0] sp,
                           input bit gaps, input int halt_after);
    logic [31:0] stream[$];
    bit ok, all_ok;
    int waitc, n, m;
    n = im_wq.size();
    m = dm_wq.size();
    do_reset();
    exp_pc = pc;
    exp_sp = sp;
    build_expect(pc);
    stream.push_back(pc);
    stream.push_back(32'(n));
    foreach (im_wq[i]) stream.push_back(im_wq[i]);
    stream.push_back(sp);
    stream.push_back(32'(m));
    foreach (dm_wq[i]) stream.push_back(dm_wq[i]);
    all_ok = 1'b1;
    foreach (stream[i]) begin
      if (all_ok) begin
        send_word(stream[i], gaps, ok);
        all_ok = all_ok & ok;
      end
    end
    check("handshake", 32'(all_ok), 32'd1);
    // After the last accept: four DM byte cycles, or straight to RUN if M==0.
    waitc = 0;
    do begin
      @(negedge clk);
      waitc++;
    end while (!cpu_run_o && waitc < 40);
    check("run_latency", 32'(waitc), (m == 0) ? 32'd1 : 32'd5);
    check("im_writes", 32'(im_cnt), 32'(4 * n));
    check("dm_writes", 32'(dm_cnt), 32'(4 * m));
    check("pc_we_count", 32'(pc_cnt), 32'd1);
    check("sp_we_count", 32'(sp_cnt), 32'd1);
    check("run_status", {28'd0, s_ready_o, halt_o, err_o, cpu_run_o}, 32'h1);
    check("cnt_start", cycle_cnt_o, 32'd0);
    instr_op_i = 6'h00;
    if (halt_after > 0) begin
      for (int c = 1; c <= halt_after; c++) begin
        check("run_cnt", cycle_cnt_o, 32'(c - 1));
        check("run_on", 32'(cpu_run_o), 32'd1);
        instr_op_i = (c == halt_after) ? OP_HALT : 6'($urandom_range(0, 62));
        @(negedge clk);
      end
      for (int h = 0; h < 3; h++) begin
        check("halt_cnt", cycle_cnt_o, 32'(halt_after));
        check("halt_status", {28'd0, s_ready_o, halt_o, err_o, cpu_run_o}, 32'h4);
        instr_op_i = 6'($urandom);
        s_valid_i  = 1'b1;
        s_data_i   = $urandom;
        @(negedge clk);
      end
      s_valid_i = 1'b0;
    end
  endtask

  // Oversized count: in the IM header (in_data=0) or the DM header (in_data=1).
  task automatic run_err(input bit in_data);
    bit ok;
    im_wq.delete();
    dm_wq.delete();
    if (in_data) im_wq.push_back($urandom);
    do_reset();
    exp_pc = 32'h0000_0200;
    exp_sp = 32'h0000_7FFC;
    build_expect(exp_pc);
    send_word(exp_pc, 1'b0, ok);
    if (in_data) begin
      send_word(32'd1, 1'b0, ok);
      send_word(im_wq[0], 1'b0, ok);
      send_word(exp_sp, 1'b0, ok);
      send_word(32'h8000_0000, 1'b0, ok);
    end else begin
      send_word(32'(MAX_WORDS + 1), 1'b0, ok);
    end
    check("err_count_accept", 32'(ok), 32'd1);
    for (int i = 0; i < 4; i++) begin
      s_valid_i  = 1'b1;
      s_data_i   = $urandom;
      instr_op_i = 6'($urandom);
      @(negedge clk);
      check("err_status", {28'd0, s_ready_o, halt_o, err_o, cpu_run_o}, 32'h2);
    end
    s_valid_i = 1'b0;
    check("err_im_writes", 32'(im_cnt), in_data ? 32'd4 : 32'd0);
    check("err_dm_writes", 32'(dm_cnt), 32'd0);
    check("err_pc_we", 32'(pc_cnt), 32'd1);
    check("err_sp_we", 32'(sp_cnt), in_data ? 32'd1 : 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit          ok;
    logic [31:0] pc, sp;
    int          n, m, h;
    rst_i      = 1'b1;
    s_valid_i  = 1'b0;
    s_data_i   = 32'd0;
    instr_op_i = 6'h00;

    // Directed example image, halt on the 5th run cycle.
    im_wq = '{32'h3C01_ABCD};
    dm_wq = '{32'h1122_3344};
    run_image(32'h0000_0000, 32'h0000_0400, 1'b0, 5);

    // Two IM words at 0x100, no DM words.
    im_wq.delete(); dm_wq.delete();
    im_wq.push_back($urandom); im_wq.push_back($urandom);
    run_image(32'h0000_0100, $urandom, 1'b0, 2);

    // Empty images: RUN right after the M accept.
    im_wq.delete(); dm_wq.delete();
    run_image(32'h0000_0ABC, 32'h0000_1234, 1'b0, 1);

    // IM address wrap past the top of a 1 KiB IM.
    im_wq.delete(); dm_wq.delete();
    for (int i = 0; i < 3; i++) im_wq.push_back($urandom);
    dm_wq.push_back($urandom);
    run_image(32'h0000_03F8, $urandom, 1'b1, 3);

    // Largest accepted image.
    im_wq.delete(); dm_wq.delete();
    for (int i = 0; i < MAX_WORDS; i++) im_wq.push_back($urandom);
    for (int i = 0; i < 3; i++) dm_wq.push_back($urandom);
    run_image(32'h0000_0000, 32'h0000_0FFC, 1'b0, 2);

    // Random images, each loaded gap-free and then with stream gaps.
    for (int it = 0; it < 6; it++) begin
      im_wq.delete(); dm_wq.delete();
      n = int'($urandom_range(0, 5));
      m = int'($urandom_range(0, 5));
      for (int i = 0; i < n; i++) im_wq.push_back($urandom);
      for (int i = 0; i < m; i++) dm_wq.push_back($urandom);
      pc = $urandom;
      sp = $urandom;
      h  = int'($urandom_range(1, 8));
      run_image(pc, sp, 1'b0, h);
      run_image(pc, sp, 1'b1, h);
    end

    // Oversized word counts.
    run_err(1'b0);
    run_err(1'b1);

    // Asynchronous reset in the middle of an IM byte sequence, then reload.
    im_wq.delete(); dm_wq.delete();
    im_wq.push_back($urandom); im_wq.push_back($urandom);
    do_reset();
    exp_pc = 32'h0000_0040;
    build_expect(exp_pc);
    send_word(exp_pc, 1'b0, ok);
    send_word(32'd2, 1'b0, ok);
    send_word(im_wq[0], 1'b0, ok);
    check("in_byte_state", 32'(im_we_o), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check("async_rst_byte", {26'd0, s_ready_o, im_we_o, dm_we_o, pc_we_o, cpu_run_o, err_o}, 32'd0);
    check("async_rst_byte_addr", 32'(im_addr_o), 32'd0);
    check("async_rst_byte_pc", pc_o, 32'd0);
    dm_wq.push_back($urandom);
    run_image(32'h0000_0040, 32'h0000_0200, 1'b1, 2);

    // Asynchronous reset during RUN, then reload.
    im_wq.delete(); dm_wq.delete();
    im_wq.push_back($urandom); dm_wq.push_back($urandom);
    run_image(32'h0000_0010, 32'h0000_0100, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    check("run_before_rst", cycle_cnt_o, 32'd2);
    #2;
    rst_i = 1'b1;
    #1;
    check("async_rst_run_cnt", cycle_cnt_o, 32'd0);
    check("async_rst_run_flags", {28'd0, s_ready_o, halt_o, err_o, cpu_run_o}, 32'd0);
    check("async_rst_run_sp", sp_o, 32'd0);
    run_image(32'h0000_0010, 32'h0000_0100, 1'b0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
